ysyx_24110015_ifu_prefetch: RTL and testbench

YSYX_24110015_IFU_PREFETCH -- requirements
Module: ysyx_24110015_ifu_prefetch

---
 rtl/ysyx_24110015_ifu_prefetch.sv | 145 ++++++++++++++
 tb/tb_ysyx_24110015_ifu_prefetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_ifu_prefetch.sv
// ysyx_24110015_ifu_prefetch: AXI-AR/R instruction prefetcher with in-order tag queue and output FIFO.
// Optional perf counters are enabled by defining YSYX_24110015_IFU_PERF_EN.
module ysyx_24110015_ifu_prefetch #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                FIFO_DEPTH = 4,
    parameter int                MAX_OUTST  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_err
`ifdef YSYX_24110015_IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int FW  = $clog2(FIFO_DEPTH);
    localparam int CW  = FW + 1;
    localparam int CW1 = CW + 1;
    localparam int TW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTST);
    localparam logic [CW:0]   DEPTH_C = CW1'(FIFO_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, araddr_q, araddr_d, base_pc;
    logic              arvalid_q, arvalid_d;
    logic [CW-1:0]     outst_q, outst_d, discard_q, discard_d;
    logic [CW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [TW-1:0]     tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [CW-1:0]     cnt, cnt_nxt, outst_r;
    logic [CW:0]       credit;
    logic              push, pop, raise;

    logic [31:0]       inst_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
    logic              err_mem  [FIFO_DEPTH];
    logic [ADDR_W-1:0] tag_mem  [MAX_OUTST];

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // next state: outst counts raised-but-unanswered requests, so a held AR already owns its credit
    always_comb begin
        cnt        = wp_q - rp_q;
        pop        = out_valid && out_ready;
        push       = rvalid && (discard_q == '0) && !redirect_valid;
        outst_r    = outst_q - CW'(rvalid);
        cnt_nxt    = redirect_valid ? '0 : cnt + CW'(push) - CW'(pop);
        credit     = {1'b0, outst_r} + {1'b0, cnt_nxt};
        raise      = (!arvalid_q || arready) && (outst_r < MAX_C) && (credit < DEPTH_C);
        base_pc    = redirect_valid ? redirect_pc : fetch_pc_q;
        fetch_pc_d = raise ? base_pc + ADDR_W'(4) : base_pc;
        araddr_d   = raise ? base_pc : araddr_q;
        arvalid_d  = raise || (arvalid_q && !arready);
        outst_d    = outst_r + CW'(raise);
        discard_d  = redirect_valid ? outst_r : discard_q - CW'(rvalid && (discard_q != '0));
        wp_d       = wp_q + CW'(push);
        rp_d       = redirect_valid ? wp_q : rp_q + CW'(pop);
        tag_wp_d   = raise ? tag_inc(tag_wp_q) : tag_wp_q;
        tag_rp_d   = rvalid ? tag_inc(tag_rp_q) : tag_rp_q;
    end

    // control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            outst_q    <= '0;
            discard_q  <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            tag_wp_q   <= '0;
            tag_rp_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            tag_wp_q   <= tag_wp_d;
            tag_rp_q   <= tag_rp_d;
        end
    end

    // buffer storage: tag PC captured when the request is raised, beat captured on arrival
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wp_q[FW-1:0]] <= rdata;
            pc_mem[wp_q[FW-1:0]]   <= tag_mem[tag_rp_q];
            err_mem[wp_q[FW-1:0]]  <= rresp != 2'b00;
        end
        if (raise) tag_mem[tag_wp_q] <= base_pc;
    end

    assign araddr    = araddr_q;
    assign arvalid   = arvalid_q;
    assign rready    = 1'b1;
    assign out_valid = wp_q != rp_q;
    assign out_inst  = out_valid ? inst_mem[rp_q[FW-1:0]] : '0;
    assign out_pc    = out_valid ? pc_mem[rp_q[FW-1:0]] : '0;
    assign out_err   = out_valid && err_mem[rp_q[FW-1:0]];

`ifdef YSYX_24110015_IFU_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d, perf_stall_q, perf_stall_d;

    // delivered-instruction and starved-consumer counters, both free-running
    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(out_valid && out_ready);
        perf_stall_d = perf_stall_q + 32'(out_ready && !out_valid);
    end

    // perf counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// tb_ysyx_24110015_ifu_prefetch: scoreboard bench with a 1-cycle-latency AXI slave model.
module tb_ysyx_24110015_ifu_prefetch;

    typedef struct packed {
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;
`ifdef YSYX_24110015_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    exp_t        exp_q[$];
    logic [31:0] pend_q[$];
    logic [31:0] ar_log[$];
    logic [31:0] err_addr = 32'h0000_0001;
    int          n_cmp = 0, n_err = 0, cyc = 0, ar_cnt = 0;
    int          n_pop = 0, pop_first = 0, pop_last = 0;

    ysyx_24110015_ifu_prefetch dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_err(out_err)
`ifdef YSYX_24110015_IFU_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic expect_seq(input logic [31:0] pc0, input int n);
        logic [31:0] p;
        for (int i = 0; i < n; i++) begin
            p = pc0 + 32'(4 * i);
            exp_q.push_back({p, p == err_addr});
        end
    endtask

    // one cycle: drive inputs at negedge, score any out handshake, run the slave
    task automatic tick(input logic ar_rdy, input logic redir, input logic [31:0] rpc);
        exp_t        e;
        logic [31:0] a;
        @(negedge clk);
        cyc++;
        arready        = ar_rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = !redir && exp_q.size() > 0;
        if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_inst", out_inst, ~e.pc);
            check("out_err", 32'(out_err), 32'(e.err));
            if (n_pop == 0) pop_first = cyc;
            pop_last = cyc;
            n_pop++;
        end
        if (pend_q.size() > 0) begin
            a      = pend_q.pop_front();
            rvalid = 1'b1;
            rdata  = ~a;
            rresp  = (a == err_addr) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
            rresp  = '0;
        end
        if (arvalid && arready) begin
            pend_q.push_back(araddr);
            ar_log.push_back(araddr);
            ar_cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        arready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = '0;
        pend_q.delete(); exp_q.delete(); ar_log.delete();
        ar_cnt = 0; n_pop = 0;
        #1;
        check("rst_arvalid", 32'(arvalid), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (exp_q.size() > 0 && k < limit) begin
            tick(1'b1, 1'b0, '0);
            k++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check("init_arvalid", 32'(arvalid), 0);
        check("init_out_valid", 32'(out_valid), 0);
        check("init_out_inst", out_inst, 0);
        check("init_out_pc", out_pc, 0);
        check("init_out_err", 32'(out_err), 0);

        do_reset();
        expect_seq(32'h8000_0000, 8);
        tick(1'b1, 1'b0, '0);
        check("first_arvalid", 32'(arvalid), 1);
        check("first_araddr", araddr, 32'h8000_0000);
        drain(40);
        check("stream_pops", n_pop, 8);
        check("stream_span", pop_last - pop_first, 7);

        do_reset();
        repeat (10) tick(1'b1, 1'b0, '0);
        check("full_ar_cnt", ar_cnt, 4);
        check("full_arvalid", 32'(arvalid), 0);
        expect_seq(32'h8000_0000, 1);
        repeat (10) tick(1'b1, 1'b0, '0);
        check("pop1_ar_cnt", ar_cnt, 5);
        check("pop1_arvalid", 32'(arvalid), 0);
        expect_seq(32'h8000_0004, 6);
        drain(40);

        do_reset();
        repeat (3) tick(1'b1, 1'b0, '0);
        exp_q.delete();
        expect_seq(32'h8000_1000, 4);
        tick(1'b1, 1'b1, 32'h8000_1000);
        tick(1'b1, 1'b0, '0);
        check("flush_out_valid", 32'(out_valid), 0);
        drain(40);

        do_reset();
        expect_seq(32'h8000_1000, 3);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, i == 1, 32'h8000_1000);
            check("hold_arvalid", 32'(arvalid), 1);
            check("hold_araddr", araddr, 32'h8000_0000);
        end
        drain(40);
        check("hold_ar0", ar_log[0], 32'h8000_0000);
        check("hold_ar1", ar_log[1], 32'h8000_1000);

        do_reset();
        err_addr = 32'h8000_0004;
        expect_seq(32'h8000_0000, 3);
        drain(40);
        err_addr = 32'h0000_0001;

        do_reset();
        expect_seq(32'hFFFF_FFFC, 3);
        tick(1'b0, 1'b1, 32'hFFFF_FFFC);
        drain(40);
        check("wrap_ar1", ar_log[1], 32'hFFFF_FFFC);
        check("wrap_ar2", ar_log[2], 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
